// File: rtl/sel_ser_pkg.sv
// ----------------------------------------------------------------------------
// sel_ser_pkg
// Shared types and constants for the selector-symbol serializer.
//   - serState_e   : transmit FSM state encoding
//   - SYM_*        : ASCII anchors used by the symbol lookup
//   - SEL_MAX      : highest selector index with a dedicated symbol
//   - FRAME_BITS   : bits per serial frame (start + 8 data [+ parity] + stop)
//   - evenParity() : even parity of a symbol
// Optional feature macro: SEL_SER_PARITY_EN (adds an even parity bit).
// ----------------------------------------------------------------------------
package sel_ser_pkg;

`ifdef SEL_SER_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } serState_e;

    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } serState_e;

    localparam int FRAME_BITS = 10;
`endif

    localparam logic [7:0] SYM_DIGIT_BASE = 8'h30;
    localparam logic [7:0] SYM_UPPER_BASE = 8'h41;
    localparam logic [7:0] SYM_LOWER_BASE = 8'h61;
    localparam logic [7:0] SYM_SPACE      = 8'h20;
    localparam logic [7:0] SYM_DOT        = 8'h2E;
    localparam logic [7:0] SYM_UNKNOWN    = 8'h3F;

    localparam logic [5:0] SEL_MAX = 6'd37;

    function automatic logic evenParity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sel_symbol_serializer_if.sv
// ----------------------------------------------------------------------------
// sel_symbol_serializer_if
// Bundles the selector inputs and the serial/status outputs of the serializer.
//   sel1      : 6-bit character selector index (to serializer)
//   sel2      : phase bit, 1 selects lowercase letters (to serializer)
//   ovr_clr   : clears the sticky overrun flag (to serializer)
//   ser_out   : serial line, idles high (from serializer)
//   busy      : frame in flight (from serializer)
//   sym_valid : one-cycle pulse as a frame starts (from serializer)
//   sym_out   : symbol of the current/last frame (from serializer)
//   overrun   : sticky pending-overwrite flag (from serializer)
// Modports: master drives the selector side, slave is the serializer.
// ----------------------------------------------------------------------------
interface sel_symbol_serializer_if;
    logic [5:0] sel1;
    logic       sel2;
    logic       ovr_clr;
    logic       ser_out;
    logic       busy;
    logic       sym_valid;
    logic [7:0] sym_out;
    logic       overrun;

    modport master (
        output sel1, sel2, ovr_clr,
        input  ser_out, busy, sym_valid, sym_out, overrun
    );

    modport slave (
        input  sel1, sel2, ovr_clr,
        output ser_out, busy, sym_valid, sym_out, overrun
    );
endinterface

// File: rtl/sel_sym_rom.sv
// ----------------------------------------------------------------------------
// sel_sym_rom
// Purely combinational selector-to-ASCII lookup.
//   sel1_i : selector index 0..63
//   sel2_i : phase bit, 1 selects lowercase for letter indices
//   sym_o  : 8-bit ASCII symbol
// Indices 0..9 are digits, 10..35 letters, 36 space, 37 dot, anything
// above SEL_MAX maps to '?'.
// ----------------------------------------------------------------------------
module sel_sym_rom
    import sel_ser_pkg::*;
(
    input  logic [5:0] sel1_i,
    input  logic       sel2_i,
    output logic [7:0] sym_o
);

    logic [7:0] selWide;

    assign selWide = {2'b00, sel1_i};

    // Range decode of the selector; the fall-through default covers the
    // unused indices above SEL_MAX.
    always_comb begin
        sym_o = SYM_UNKNOWN;
        if (sel1_i <= 6'd9) begin
            sym_o = SYM_DIGIT_BASE + selWide;
        end else if (sel1_i <= 6'd35) begin
            sym_o = (sel2_i ? SYM_LOWER_BASE : SYM_UPPER_BASE) + (selWide - 8'd10);
        end else if (sel1_i == 6'd36) begin
            sym_o = SYM_SPACE;
        end else if (sel1_i == SEL_MAX) begin
            sym_o = SYM_DOT;
        end
    end

endmodule

// File: rtl/sel_symbol_serializer.sv
// ----------------------------------------------------------------------------
// sel_symbol_serializer
// Watches the upstream character selector, turns each change into an ASCII
// symbol and shifts it out as an asynchronous-style frame: start bit (0),
// 8 data bits LSB first, optional even parity bit, stop bit (1).
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : sel_symbol_serializer_if.slave (sel1/sel2/ovr_clr in,
//         ser_out/busy/sym_valid/sym_out/overrun out)
// Parameter:
//   BIT_DIV : clocks per serial bit, 1..255
// Optional feature macro: SEL_SER_PARITY_EN (inserts a PARITY state between
// DATA and STOP carrying ^sym_out).
// ----------------------------------------------------------------------------
module sel_symbol_serializer
    import sel_ser_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    sel_symbol_serializer_if.slave   bus
);

    localparam logic [7:0] LAST_TICK = 8'(BIT_DIV - 1);

    serState_e  state_q, state_d;
    logic [7:0] bitTimer_q, bitTimer_d;
    logic [2:0] bitIdx_q, bitIdx_d;
    logic [5:0] sel1_q;
    logic [7:0] pending_q, pending_d;
    logic       pendingValid_q, pendingValid_d;
    logic [7:0] symOut_q, symOut_d;
    logic       symValid_q, symValid_d;
    logic       serOut_q, serOut_d;
    logic       overrun_q, overrun_d;

    logic [7:0] romSym;
    logic       selChange;
    logic       bitDone;
    logic       consume;

    sel_sym_rom uSymRom (
        .sel1_i (bus.sel1),
        .sel2_i (bus.sel2),
        .sym_o  (romSym)
    );

    assign selChange = (bus.sel1 != sel1_q);
    assign bitDone   = (bitTimer_q == LAST_TICK);

    // The selector history register also loads during reset, so leaving
    // reset with an unchanged selector never produces an event.
    always_ff @(posedge clk) begin
        sel1_q <= bus.sel1;
        if (rst) begin
            state_q        <= ST_IDLE;
            bitTimer_q     <= 8'd0;
            bitIdx_q       <= 3'd0;
            pending_q      <= 8'h00;
            pendingValid_q <= 1'b0;
            symOut_q       <= 8'h00;
            symValid_q     <= 1'b0;
            serOut_q       <= 1'b1;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bitTimer_q     <= bitTimer_d;
            bitIdx_q       <= bitIdx_d;
            pending_q      <= pending_d;
            pendingValid_q <= pendingValid_d;
            symOut_q       <= symOut_d;
            symValid_q     <= symValid_d;
            serOut_q       <= serOut_d;
            overrun_q      <= overrun_d;
        end
    end

    // Transmit FSM. The pending entry is consumed either from IDLE or at the
    // final tick of STOP, which is what lets frames run back to back.
    always_comb begin
        state_d    = state_q;
        bitTimer_d = bitTimer_q;
        bitIdx_d   = bitIdx_q;
        consume    = 1'b0;

        if (state_q != ST_IDLE) begin
            bitTimer_d = bitDone ? 8'd0 : bitTimer_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                bitTimer_d = 8'd0;
                if (pendingValid_q) begin
                    consume = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bitDone) begin
                    state_d  = ST_DATA;
                    bitIdx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bitDone) begin
                    if (bitIdx_q == 3'd7) begin
`ifdef SEL_SER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
`ifdef SEL_SER_PARITY_EN
            ST_PARITY: begin
                if (bitDone) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bitDone) begin
                    if (pendingValid_q) begin
                        consume = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending buffer, overrun flag and the registered serial line. A new
    // event always wins the pending slot; it only counts as an overrun when
    // the old entry is still unsent after this edge.
    always_comb begin
        symOut_d       = consume ? pending_q : symOut_q;
        symValid_d     = consume;
        pending_d      = pending_q;
        pendingValid_d = pendingValid_q;
        overrun_d      = overrun_q;
        serOut_d       = 1'b1;

        if (selChange) begin
            pending_d      = romSym;
            pendingValid_d = 1'b1;
        end else if (consume) begin
            pendingValid_d = 1'b0;
        end

        if (selChange && pendingValid_q && !consume) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end

        // The line is registered from next-state values so it changes in
        // lockstep with the state register, without combinational glitches.
        case (state_d)
            ST_START:  serOut_d = 1'b0;
            ST_DATA:   serOut_d = symOut_d[bitIdx_d];
`ifdef SEL_SER_PARITY_EN
            ST_PARITY: serOut_d = evenParity(symOut_d);
`endif
            default:   serOut_d = 1'b1;
        endcase
    end

    assign bus.ser_out   = serOut_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sym_valid = symValid_q;
    assign bus.sym_out   = symOut_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sel_symbol_serializer.sv
// ----------------------------------------------------------------------------
// tb_sel_symbol_serializer
// Directed bench for sel_symbol_serializer with BIT_DIV=4. Honours the
// SEL_SER_PARITY_EN macro so the expected frame grows to 11 bits.
// ----------------------------------------------------------------------------
module tb_sel_symbol_serializer;

    localparam int BIT_DIV = 4;
`ifdef SEL_SER_PARITY_EN
    localparam int TB_FRAME_BITS = 11;
`else
    localparam int TB_FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = TB_FRAME_BITS * BIT_DIV;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sel_symbol_serializer_if tif ();

    sel_symbol_serializer #(
        .BIT_DIV (BIT_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] s1, input logic s2, input logic clr);
        tif.sel1    = s1;
        tif.sel2    = s2;
        tif.ovr_clr = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit b of symbol sym.
    function automatic logic frameBit(input logic [7:0] sym, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return sym[b-1];
        if (TB_FRAME_BITS == 11 && b == 9) return ^sym;
        return 1'b1;
    endfunction

    // Called in the first START cycle; walks the whole frame and leaves the
    // bench sampling the cycle right after the frame.
    task automatic checkFrame(input logic [7:0] sym);
        for (int c = 0; c < FRAME_CYC; c++) begin
            checkOutput("frame_line", tif.ser_out, frameBit(sym, c / BIT_DIV));
            checkOutput("frame_busy", tif.busy, 1);
            if (c > 0) checkOutput("frame_valid_low", tif.sym_valid, 0);
            tick();
        end
    endtask

    logic [5:0] vecSel1 [9] = '{6'd1, 6'd10, 6'd40, 6'd36, 6'd37, 6'd38, 6'd9, 6'd35, 6'd3};
    logic       vecSel2 [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] vecSym  [9] = '{8'h31, 8'h61, 8'h3F, 8'h20, 8'h2E, 8'h3F, 8'h39, 8'h5A, 8'h33};

    initial begin
        bit found;
        bit gap;

        checks = 0;
        errors = 0;

        // Reset with a steady selector.
        rst = 1'b1;
        applyStimulus(6'd0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("rst_ser_out", tif.ser_out, 1);
        checkOutput("rst_busy", tif.busy, 0);
        checkOutput("rst_sym_valid", tif.sym_valid, 0);
        checkOutput("rst_sym_out", tif.sym_out, 8'h00);
        checkOutput("rst_overrun", tif.overrun, 0);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("no_event_from_rst_busy", tif.busy, 0);
        checkOutput("no_event_from_rst_valid", tif.sym_valid, 0);

        // Single frames, one per selector change.
        $display("[TB] single-frame vectors");
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecSel1[v], vecSel2[v], 1'b0);
            tick();
            checkOutput("event_edge_busy", tif.busy, 0);
            tick();
            checkOutput("start_sym_valid", tif.sym_valid, 1);
            checkOutput("start_sym_out", tif.sym_out, vecSym[v]);
            checkFrame(vecSym[v]);
            checkOutput("after_frame_busy", tif.busy, 0);
            checkOutput("after_frame_line", tif.ser_out, 1);
        end

        // Three changes inside one frame; ovr_clr asserted with the overrun.
        $display("[TB] overrun sequence");
        applyStimulus(6'd5, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("ovr_first_sym", tif.sym_out, 8'h35);
        repeat (5) tick();
        applyStimulus(6'd6, 1'b0, 1'b0);
        tick();
        checkOutput("ovr_not_yet", tif.overrun, 0);
        repeat (5) tick();
        applyStimulus(6'd7, 1'b0, 1'b1);
        tick();
        applyStimulus(6'd7, 1'b0, 1'b0);
        checkOutput("ovr_set_wins", tif.overrun, 1);
        found = 1'b0;
        gap   = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (tif.sym_valid) begin
                found = 1'b1;
                break;
            end
            if (!tif.busy) gap = 1'b1;
            tick();
        end
        checkOutput("ovr_next_frame_found", found, 1);
        checkOutput("ovr_no_idle_gap", gap, 0);
        checkOutput("ovr_third_sym", tif.sym_out, 8'h37);
        checkOutput("ovr_sticky", tif.overrun, 1);
        checkFrame(8'h37);
        checkOutput("ovr_idle_after", tif.busy, 0);
        for (int n = 0; n < 8; n++) begin
            checkOutput("ovr_second_never_sent", tif.sym_valid, 0);
            tick();
        end
        applyStimulus(6'd7, 1'b0, 1'b1);
        tick();
        applyStimulus(6'd7, 1'b0, 1'b0);
        checkOutput("ovr_cleared", tif.overrun, 0);

        // Event lands on the very edge STOP ends while pending is full.
        $display("[TB] same-edge consume and refill");
        applyStimulus(6'd1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("edge_first_sym", tif.sym_out, 8'h31);
        repeat (2) tick();
        applyStimulus(6'd2, 1'b0, 1'b0);
        tick();
        repeat (FRAME_CYC - 4) tick();
        applyStimulus(6'd4, 1'b0, 1'b0);
        tick();
        checkOutput("edge_b_valid", tif.sym_valid, 1);
        checkOutput("edge_b_sym", tif.sym_out, 8'h32);
        checkOutput("edge_b_no_overrun", tif.overrun, 0);
        checkFrame(8'h32);
        checkOutput("edge_c_valid", tif.sym_valid, 1);
        checkOutput("edge_c_sym", tif.sym_out, 8'h34);
        checkOutput("edge_c_no_overrun", tif.overrun, 0);
        checkFrame(8'h34);
        checkOutput("edge_idle_after", tif.busy, 0);

        // Reset in the middle of DATA with a symbol pending.
        $display("[TB] reset mid-frame");
        applyStimulus(6'd8, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rstmid_sym", tif.sym_out, 8'h38);
        repeat (3) tick();
        applyStimulus(6'd9, 1'b0, 1'b0);
        tick();
        repeat (5) tick();
        checkOutput("rstmid_busy_before", tif.busy, 1);
        rst = 1'b1;
        tick();
        checkOutput("rstmid_line", tif.ser_out, 1);
        checkOutput("rstmid_busy", tif.busy, 0);
        checkOutput("rstmid_sym_out", tif.sym_out, 8'h00);
        checkOutput("rstmid_valid", tif.sym_valid, 0);
        rst = 1'b0;
        tick();
        for (int n = 0; n < 12; n++) begin
            checkOutput("rstmid_no_spurious_busy", tif.busy, 0);
            checkOutput("rstmid_no_spurious_valid", tif.sym_valid, 0);
            checkOutput("rstmid_line_idle", tif.ser_out, 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
